// File: rtl/demux_dispatcher_pkg.sv
// Shared types and constants for the 1-to-4 demux dispatcher.
// The state encoding and channel geometry live here so the top and the decoder agree.
package demux_dispatcher_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   // Round-robin successor; channel 3 wraps back to 0 through the natural overflow.
   function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
      return ch + CH_W'(1);
   endfunction

endpackage

// File: rtl/onehot_decode_2to4.sv
// 2-to-4 one-hot decoder with enable.
// When disabled, all outputs are low, so at most one bit can ever be high.
module onehot_decode_2to4 (
   input  logic       en,
   input  logic [1:0] sel,
   output logic [3:0] y
);

   always_comb begin
      y = 4'b0000;
      if (en) begin
         y[sel] = 1'b1;
      end
   end

endmodule

// File: rtl/demux_dispatcher.sv
// Routes a valid/ready stream to one of four channels through a one-entry output register.
// Destination comes from in_dest, or from a round-robin pointer that advances every BURST_LEN beats.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | output register empty, in_ready=1, no channel valid
//   HOLD  | beat held for cur_dest; it can be replaced on the same edge it drains
module demux_dispatcher
   import demux_dispatcher_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_LEN = 4,
   parameter int unsigned CNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rr_mode,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   in_dest,
   output logic [NUM_CH-1:0] out_valid,
   input  logic [NUM_CH-1:0] out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CH_W-1:0]   cur_dest,
   output logic [CNT_W-1:0]  sent_count
);

   localparam int unsigned BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_LEN - 1);

   state_t              state_q;
   state_t              state_d;
   logic [DATA_W-1:0]   data_q;
   logic [CH_W-1:0]     dest_q;
   logic [CH_W-1:0]     rr_ptr_q;
   logic [BC_W-1:0]     burst_cnt_q;
   logic [CNT_W-1:0]    sent_q;

   logic                accept;
   logic                drain;
   logic                holding;
   logic [CH_W-1:0]     accept_dest;

   assign holding     = (state_q == HOLD);

   // Bypass: a held beat that drains this edge frees the register for a new one.
   assign in_ready    = !holding || out_ready[dest_q];
   assign accept      = in_valid && in_ready;
   assign drain       = |(out_valid & out_ready);
   assign accept_dest = rr_mode ? rr_ptr_q : in_dest;

   onehot_decode_2to4 u_valid_dec (
      .en  (holding),
      .sel (dest_q),
      .y   (out_valid)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (drain && !accept) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         dest_q <= '0;
      end else if (accept) begin
         data_q <= in_data;
         dest_q <= accept_dest;
      end
   end

   // Leaving round-robin mode abandons the partial burst; the pointer itself is kept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else if (!rr_mode) begin
         burst_cnt_q <= '0;
      end else if (accept) begin
         if (burst_cnt_q == BURST_LAST) begin
            burst_cnt_q <= '0;
            rr_ptr_q    <= next_ch(rr_ptr_q);
         end else begin
            burst_cnt_q <= burst_cnt_q + BC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sent_q <= '0;
      end else if (drain) begin
         sent_q <= sent_q + CNT_W'(1);
      end
   end

   assign out_data   = data_q;
   assign cur_dest   = (!holding && rr_mode) ? rr_ptr_q : dest_q;
   assign sent_count = sent_q;

endmodule
